// File: rtl/ram_resp_if.sv
// ram_resp_if: request/response bus between the SoC external RAM port and its responder.
interface ram_resp_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;
    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_error, mem_rdata
    );
    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_error, mem_rdata
    );
endinterface

// File: rtl/ram_resp.sv
// ram_resp: word-organised RAM responder with byte strobes, fixed response latency and
// an error response for out-of-range addresses; one request outstanding at a time.
module ram_resp #(
    parameter int ram_depth = 16,
    parameter int latency   = 2
) (
    input  logic      clock,
    input  logic      reset,
    ram_resp_if.slave bus,
    output logic      overrun
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t               r_state, w_next;
    logic [3:0]           r_count;
    logic                 r_ready, r_error;
    logic [31:0]          r_rdata;
    logic [31:0]          r_mem [2**ram_depth];
    logic                 w_accept, w_done, w_in_range, w_write, w_unused;
    logic [ram_depth-1:0] w_idx;

    if (latency < 1 || latency > 15) begin : g_bad_latency
        $error("ram_resp: latency %0d outside 1..15", latency);
    end

    assign w_in_range = (bus.mem_addr >> (ram_depth + 2)) == 32'd0;
    assign w_idx      = bus.mem_addr[ram_depth+1:2];
    assign w_write    = |bus.mem_wstrb;
    assign w_unused   = &{1'b0, bus.mem_instr, bus.mem_addr[1:0]};
    // with latency>1 the response cycle still belongs to the previous request
    assign w_accept   = bus.mem_valid && r_state == IDLE && !(r_ready && latency > 1);

    always_ff @(posedge clock)
        r_state <= !reset ? IDLE : w_next;

    always_comb begin
        w_next = r_state == WAIT ? (r_count == 4'd1 ? IDLE : WAIT) : (w_accept && latency > 1 ? WAIT : IDLE);
        w_done = r_state == WAIT ? r_count == 4'd1 : w_accept && latency == 1;
    end

    always_comb begin
        bus.mem_ready = r_ready;
        bus.mem_error = r_ready && r_error;
        bus.mem_rdata = r_ready ? r_rdata : 32'd0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= 4'd0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_rdata <= 32'd0;
            overrun <= 1'b0;
        end else begin
            r_count <= w_accept ? 4'(latency - 1) : r_state == WAIT ? r_count - 4'd1 : r_count;
            r_ready <= w_done;
            r_error <= w_accept ? !w_in_range : r_error;
            r_rdata <= w_accept ? (w_in_range && !w_write ? r_mem[w_idx] : 32'd0) : r_rdata;
            overrun <= overrun | (bus.mem_valid && !w_accept);
        end
    end

    // writes land at the request edge so a back-to-back read sees the new data
    always_ff @(posedge clock)
        if (reset && w_accept && w_in_range)
            for (int i = 0; i < 4; i++)
                if (bus.mem_wstrb[i])
                    r_mem[w_idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
endmodule

// File: tb/tb_ram_resp.sv
// tb_ram_resp: four responders (latency 2, 1, 4, 3) driven with directed requests; a forked
// monitor matches every ready pulse against a queue of expected responses.
module tb_ram_resp;
    typedef struct {
        int          id;
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  v     = 4'd0;
    logic [31:0] a  [4];
    logic [31:0] wd [4];
    logic [3:0]  ws [4];
    wire  [3:0]  rdy, err, ov;
    wire  [31:0] rd [4];
    int          lat [4] = '{2, 1, 4, 3};
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q [$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 4 : 3;
        ram_resp_if b ();
        assign b.mem_valid = v[g];
        assign b.mem_instr = a[g][4];
        assign b.mem_addr  = a[g];
        assign b.mem_wdata = wd[g];
        assign b.mem_wstrb = ws[g];
        assign rdy[g]      = b.mem_ready;
        assign err[g]      = b.mem_error;
        assign rd[g]       = b.mem_rdata;
        ram_resp #(.ram_depth(16), .latency(LAT)) dut (
            .clock  (clock),
            .reset  (reset),
            .bus    (b),
            .overrun(ov[g])
        );
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        int j;
        forever begin
            @(negedge clock);
            for (int k = 0; k < 4; k++) begin
                if (rdy[k] === 1'b1) begin
                    j = -1;
                    for (int i = 0; i < q.size(); i++)
                        if (j < 0 && q[i].id == k) j = i;
                    if (j < 0)
                        chk($sformatf("unexpected_ready_dut%0d", k), 32'd1, 32'd0);
                    else begin
                        chk($sformatf("resp_cycle_dut%0d", k), cyc, q[j].cyc);
                        chk($sformatf("resp_error_dut%0d", k), {31'd0, err[k]}, {31'd0, q[j].err});
                        chk($sformatf("resp_rdata_dut%0d", k), rd[k], q[j].data);
                        q.delete(j);
                    end
                end else
                    chk($sformatf("idle_out_dut%0d", k), {31'd0, rdy[k] | err[k] | (|rd[k])}, 32'd0);
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(int id, logic [31:0] addr, logic [31:0] data, logic [3:0] strb,
                         bit resp, bit eerr, logic [31:0] edata);
        v[id]  = 1'b1;
        a[id]  = addr;
        wd[id] = data;
        ws[id] = strb;
        if (resp) q.push_back(exp_t'{id, cyc + lat[id], eerr, edata});
        @(negedge clock);
        v[id] = 1'b0;
    endtask

    task automatic wr(int id, logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
        drive(id, addr, data, strb, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic rdw(int id, logic [31:0] addr, logic [31:0] edata);
        drive(id, addr, 32'd0, 4'd0, 1'b1, 1'b0, edata);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            a[i]  = 32'd0;
            wd[i] = 32'd0;
            ws[i] = 4'd0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_overrun_dut%0d", k), {31'd0, ov[k]}, 32'd0);
            chk($sformatf("reset_out_dut%0d", k), {31'd0, rdy[k] | err[k] | (|rd[k])}, 32'd0);
        end
        fork
            monitor();
        join_none
        idle(2);
        // latency 2: full/partial writes, out-of-range, address aliasing
        wr(0, 32'h0, 32'h1234_5678, 4'hF);          idle(3);
        rdw(0, 32'h0, 32'h1234_5678);                idle(3);
        wr(0, 32'h100, 32'hDEAD_BEEF, 4'hF);         idle(3);
        wr(0, 32'h100, 32'h0011_2233, 4'b0101);      idle(3);
        rdw(0, 32'h100, 32'hDE11_BE33);              idle(3);
        drive(0, 32'h0004_0000, 32'd0, 4'd0, 1'b1, 1'b1, 32'd0);               idle(3);
        drive(0, 32'h0004_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'd0);       idle(3);
        rdw(0, 32'h0, 32'h1234_5678);                idle(3);
        wr(0, 32'h200, 32'hFFFF_FFFF, 4'hF);         idle(3);
        wr(0, 32'h200, 32'h1122_3344, 4'b1010);      idle(3);
        rdw(0, 32'h203, 32'h11FF_33FF);              idle(3);
        wr(0, 32'h3FFFC, 32'hCAFE_F00D, 4'hF);       idle(3);
        rdw(0, 32'h3FFFC, 32'hCAFE_F00D);            idle(3);
        rdw(0, 32'h0, 32'h1234_5678);                idle(3);
        chk("overrun_dut0", {31'd0, ov[0]}, 32'd0);
        // latency 1: back-to-back requests, read-after-write
        wr(1, 32'h8, 32'h0000_0055, 4'hF);
        rdw(1, 32'h8, 32'h0000_0055);                idle(2);
        wr(1, 32'hC, 32'hAABB_CCDD, 4'hF);
        wr(1, 32'hC, 32'h0000_0011, 4'b0001);
        rdw(1, 32'hC, 32'hAABB_CC11);                idle(2);
        chk("overrun_dut1", {31'd0, ov[1]}, 32'd0);
        // latency 4: requests in WAIT and in the response cycle are dropped
        wr(2, 32'h40, 32'h1111_1111, 4'hF);          idle(5);
        rdw(2, 32'h40, 32'h1111_1111);               idle(1);
        drive(2, 32'h40, 32'h0000_0BAD, 4'hF, 1'b0, 1'b0, 32'd0);              idle(4);
        chk("overrun_set_dut2", {31'd0, ov[2]}, 32'd1);
        rdw(2, 32'h40, 32'h1111_1111);               idle(3);
        drive(2, 32'h40, 32'h0000_0022, 4'hF, 1'b0, 1'b0, 32'd0);              idle(5);
        rdw(2, 32'h40, 32'h1111_1111);               idle(6);
        chk("overrun_sticky_dut2", {31'd0, ov[2]}, 32'd1);
        // latency 3: reset while a read is pending drops the response
        wr(3, 32'h10, 32'h0000_0077, 4'hF);          idle(4);
        drive(3, 32'h10, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("post_reset_overrun_dut%0d", k), {31'd0, ov[k]}, 32'd0);
        idle(4);
        rdw(3, 32'h10, 32'h0000_0077);               idle(6);
        chk("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
